// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// Operand-select stage in front of the 32-bit ALU. Captures decoded
// instructions over valid/ready, translates alu_op/funct into the ALU
// control code, applies write-back forwarding to captured and held
// operands, and presents registered operands from the output entry.
// A two-entry (output + skid) buffer keeps in_ready purely registered.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // Upstream (decode) side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alu_src,
    input  logic [1:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    // Write-back forwarding source
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    // Pipeline control
    input  logic            flush,
    // Downstream (ALU) side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctl,
    output logic [4:0]      out_rd,
    output logic            out_reg_write
);

    // ALU control encodings
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    // One buffered instruction. Both rs values are kept so that forwarding
    // can keep refreshing them while the entry waits.
    typedef struct packed {
        logic            valid;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [3:0]      ctl;
        logic [4:0]      rd;
        logic            reg_write;
    } entry_t;

    // Translate alu_op/funct3/funct7[5] into the ALU control code.
    // SUB is only chosen for register-register ops: an I-type ADDI can
    // carry a 1 in bit 30 as part of its immediate.
    function automatic logic [3:0] decode_ctl(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic       funct7_5,
        input logic       alu_src
    );
        logic [3:0] ctl;
        case (alu_op)
            2'b00: ctl = CTL_ADD;
            2'b01: ctl = CTL_SUB;
            2'b11: ctl = CTL_NOR;
            2'b10: begin
                case (funct3)
                    3'b000:  ctl = (funct7_5 && !alu_src) ? CTL_SUB : CTL_ADD;
                    3'b010:  ctl = CTL_SLT;
                    3'b110:  ctl = CTL_OR;
                    3'b111:  ctl = CTL_AND;
                    default: ctl = CTL_ADD;
                endcase
            end
            default: ctl = CTL_ADD;
        endcase
        return ctl;
    endfunction

    // Replace a source value with write-back data when the write targets
    // the same, non-zero register.
    function automatic logic [XLEN-1:0] fwd_val(
        input logic [4:0]      src_addr,
        input logic [XLEN-1:0] src_val,
        input logic            we,
        input logic [4:0]      rd,
        input logic [XLEN-1:0] data
    );
        logic [XLEN-1:0] res;
        if (we && (rd != 5'd0) && (rd == src_addr)) begin
            res = data;
        end else begin
            res = src_val;
        end
        return res;
    endfunction

    // Apply forwarding to both source values of an entry. rs2 is updated
    // even for immediate ops so the entry always holds a coherent value.
    function automatic entry_t fwd_entry(
        input entry_t          e,
        input logic            we,
        input logic [4:0]      rd,
        input logic [XLEN-1:0] data
    );
        entry_t r;
        r         = e;
        r.rs1_val = fwd_val(e.rs1_addr, e.rs1_val, we, rd, data);
        r.rs2_val = fwd_val(e.rs2_addr, e.rs2_val, we, rd, data);
        return r;
    endfunction

    entry_t o_q, o_d;   // output entry, drives the ALU
    entry_t s_q, s_d;   // skid entry, absorbs one instruction under stall

    entry_t in_ent_s;   // incoming instruction, decoded and forwarded
    entry_t o_fwd_s;    // output entry after this cycle's forwarding
    entry_t s_fwd_s;    // skid entry after this cycle's forwarding
    logic   in_xfer_s;
    logic   out_xfer_s;

    // Ready only reflects registered skid occupancy: no combinational
    // path from out_ready back to in_ready.
    assign in_ready   = ~s_q.valid;
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = o_q.valid & out_ready;

    // Build the incoming entry and refresh held entries with forwarding.
    always_comb begin
        in_ent_s           = '0;
        in_ent_s.valid     = 1'b1;
        in_ent_s.rs1_addr  = in_rs1_addr;
        in_ent_s.rs2_addr  = in_rs2_addr;
        in_ent_s.rs1_val   = fwd_val(in_rs1_addr, in_rs1_data, wb_we, wb_rd, wb_data);
        in_ent_s.rs2_val   = fwd_val(in_rs2_addr, in_rs2_data, wb_we, wb_rd, wb_data);
        in_ent_s.imm       = in_imm;
        in_ent_s.alu_src   = in_alu_src;
        in_ent_s.ctl       = decode_ctl(in_alu_op, in_funct3, in_funct7_5, in_alu_src);
        in_ent_s.rd        = in_rd;
        in_ent_s.reg_write = in_reg_write;
        o_fwd_s            = fwd_entry(o_q, wb_we, wb_rd, wb_data);
        s_fwd_s            = fwd_entry(s_q, wb_we, wb_rd, wb_data);
    end

    // Entry movement: flush wins; otherwise a free output entry takes the
    // skid entry first (FIFO order) or the new input, and a stalled output
    // entry diverts an accepted input into the skid entry.
    always_comb begin
        o_d = o_fwd_s;
        s_d = s_fwd_s;
        if (flush) begin
            o_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (!o_q.valid || out_xfer_s) begin
            if (s_q.valid) begin
                // in_ready is low while the skid entry is full, so no
                // input can arrive in this branch.
                o_d       = s_fwd_s;
                s_d.valid = 1'b0;
            end else if (in_xfer_s) begin
                o_d = in_ent_s;
            end else begin
                o_d.valid = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                s_d = in_ent_s;
            end else begin
                s_d = s_fwd_s;
            end
        end
    end

    // Entry registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
            s_q <= '0;
        end else begin
            o_q <= o_d;
            s_q <= s_d;
        end
    end

    // ALU-facing outputs come straight from the output entry registers.
    assign out_valid     = o_q.valid;
    assign alu_a         = o_q.rs1_val;
    assign alu_b         = o_q.alu_src ? o_q.imm : o_q.rs2_val;
    assign alu_ctl       = o_q.ctl;
    assign out_rd        = o_q.rd;
    assign out_reg_write = o_q.reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: a table of single-instruction
// decode/select vectors plus hand-written back-pressure, forwarding,
// flush and asynchronous-reset sequences.
module tb_ex_operand_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1_addr, in_rs2_addr;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic            in_alu_src;
    logic [1:0]      in_alu_op;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic [4:0]      in_rd;
    logic            in_reg_write;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [3:0]      alu_ctl;
    logic [4:0]      out_rd;
    logic            out_reg_write;

    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_op(in_alu_op),
        .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  alu_op;
        logic [2:0]  f3;
        logic        f7;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_ctl;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
        in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0;
        in_alu_src = 1'b0; in_alu_op = 2'b10; in_funct3 = 3'b000;
        in_funct7_5 = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0;
    endtask

    task automatic drive_rr(input logic [4:0] a1, input logic [31:0] d1,
                            input logic [4:0] a2, input logic [31:0] d2);
        in_valid = 1'b1; in_rs1_addr = a1; in_rs1_data = d1;
        in_rs2_addr = a2; in_rs2_data = d2; in_imm = 32'd0;
        in_alu_src = 1'b0; in_alu_op = 2'b10; in_funct3 = 3'b000;
        in_funct7_5 = 1'b0; in_rd = 5'd9; in_reg_write = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"add",   2'b10, 3'b000, 1'b0, 1'b0, 32'd5,  32'd7,   32'd0,          5'd1,  1'b1, 32'd5,  32'd7,          4'b0010};
        vecs[1] = '{"sub",   2'b10, 3'b000, 1'b1, 1'b0, 32'd20, 32'd3,   32'd0,          5'd2,  1'b1, 32'd20, 32'd3,          4'b0110};
        vecs[2] = '{"addi7", 2'b10, 3'b000, 1'b1, 1'b1, 32'd9,  32'd100, 32'hFFFF_FFFF,  5'd3,  1'b1, 32'd9,  32'hFFFF_FFFF,  4'b0010};
        vecs[3] = '{"slt",   2'b10, 3'b010, 1'b0, 1'b0, 32'd1,  32'd2,   32'd0,          5'd4,  1'b1, 32'd1,  32'd2,          4'b0111};
        vecs[4] = '{"or",    2'b10, 3'b110, 1'b0, 1'b0, 32'hF0, 32'h0F,  32'd0,          5'd5,  1'b1, 32'hF0, 32'h0F,         4'b0001};
        vecs[5] = '{"and",   2'b10, 3'b111, 1'b0, 1'b0, 32'hFF, 32'h3C,  32'd0,          5'd6,  1'b1, 32'hFF, 32'h3C,         4'b0000};
        vecs[6] = '{"beq",   2'b01, 3'b000, 1'b0, 1'b0, 32'd8,  32'd8,   32'd0,          5'd0,  1'b0, 32'd8,  32'd8,          4'b0110};
        vecs[7] = '{"nor",   2'b11, 3'b000, 1'b0, 1'b0, 32'hA,  32'h5,   32'd0,          5'd7,  1'b1, 32'hA,  32'h5,          4'b1100};
        vecs[8] = '{"ldst",  2'b00, 3'b010, 1'b1, 1'b1, 32'h100,32'h77,  32'h10,         5'd8,  1'b1, 32'h100,32'h10,         4'b0010};
        vecs[9] = '{"f3oth", 2'b10, 3'b001, 1'b1, 1'b0, 32'd3,  32'd4,   32'd0,          5'd10, 1'b1, 32'd3,  32'd4,          4'b0010};

        rst = 1'b1; out_ready = 1'b1; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        idle_inputs();
        @(negedge clk); @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_alu_a",     alu_a, 32'd0);
        check("rst_alu_b",     alu_b, 32'd0);
        check("rst_alu_ctl",   32'(alu_ctl), 32'd0);
        check("rst_out_rd",    32'(out_rd), 32'd0);
        check("rst_out_rw",    32'(out_reg_write), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: one instruction per cycle, out_ready held high
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_alu_op = vecs[i].alu_op; in_funct3 = vecs[i].f3;
            in_funct7_5 = vecs[i].f7; in_alu_src = vecs[i].src;
            in_rs1_addr = 5'd11; in_rs2_addr = 5'd12;
            in_rs1_data = vecs[i].rs1; in_rs2_data = vecs[i].rs2; in_imm = vecs[i].imm;
            in_rd = vecs[i].rd; in_reg_write = vecs[i].rw;
            step();
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, "_a"},     alu_a, vecs[i].exp_a);
            check({vecs[i].name, "_b"},     alu_b, vecs[i].exp_b);
            check({vecs[i].name, "_ctl"},   32'(alu_ctl), 32'(vecs[i].exp_ctl));
            check({vecs[i].name, "_rd"},    32'(out_rd), 32'(vecs[i].rd));
            check({vecs[i].name, "_rw"},    32'(out_reg_write), 32'(vecs[i].rw));
            check({vecs[i].name, "_inrdy"}, 32'(in_ready), 32'd1);
        end
        idle_inputs();
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure: A, B accepted, C waits, then FIFO drain
        out_ready = 1'b0;
        drive_rr(5'd1, 32'hA, 5'd2, 32'h1);
        step();
        check("bp_A_in_ready", 32'(in_ready), 32'd1);
        check("bp_A_a", alu_a, 32'hA);
        drive_rr(5'd1, 32'hB, 5'd2, 32'h2);
        step();
        check("bp_B_in_ready", 32'(in_ready), 32'd0);
        check("bp_B_hold_a", alu_a, 32'hA);
        drive_rr(5'd1, 32'hC, 5'd2, 32'h3);
        step();
        check("bp_C_wait_rdy", 32'(in_ready), 32'd0);
        check("bp_C_wait_a", alu_a, 32'hA);
        check("bp_C_wait_v", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_out_B_a", alu_a, 32'hB);
        check("bp_out_B_v", 32'(out_valid), 32'd1);
        check("bp_out_B_rdy", 32'(in_ready), 32'd1);
        step();
        check("bp_out_C_a", alu_a, 32'hC);
        check("bp_out_C_b", alu_b, 32'h3);
        check("bp_out_C_v", 32'(out_valid), 32'd1);
        idle_inputs();
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Forwarding at capture
        drive_rr(5'd3, 32'h10, 5'd2, 32'h20);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hAB;
        step();
        check("fwd_cap_a", alu_a, 32'hAB);
        check("fwd_cap_b", alu_b, 32'h20);
        wb_we = 1'b0;
        idle_inputs();
        step();

        // Forwarding into a held entry
        out_ready = 1'b0;
        drive_rr(5'd6, 32'h66, 5'd4, 32'h22);
        step();
        check("fwd_held_pre", alu_b, 32'h22);
        idle_inputs();
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h55;
        step();
        check("fwd_held_b", alu_b, 32'h55);
        check("fwd_held_a", alu_a, 32'h66);
        wb_we = 1'b0;
        out_ready = 1'b1;
        step();

        // Register 0 is never forwarded
        drive_rr(5'd0, 32'h33, 5'd0, 32'h44);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
        step();
        check("fwd_x0_a", alu_a, 32'h33);
        check("fwd_x0_b", alu_b, 32'h44);
        wb_we = 1'b0;
        idle_inputs();
        step();

        // Flush with a same-cycle input transfer (skid empty)
        out_ready = 1'b0;
        drive_rr(5'd1, 32'h70, 5'd2, 32'h0);
        step();
        drive_rr(5'd1, 32'h71, 5'd2, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_inputs();
        check("flush1_valid", 32'(out_valid), 32'd0);
        check("flush1_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        check("flush1_never", 32'(out_valid), 32'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        drive_rr(5'd1, 32'h80, 5'd2, 32'h0);
        step();
        drive_rr(5'd1, 32'h81, 5'd2, 32'h0);
        step();
        check("flush2_full", 32'(in_ready), 32'd0);
        drive_rr(5'd1, 32'h82, 5'd2, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_inputs();
        check("flush2_valid", 32'(out_valid), 32'd0);
        check("flush2_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        check("flush2_never", 32'(out_valid), 32'd0);

        // Async reset mid-stall with both entries full
        out_ready = 1'b0;
        drive_rr(5'd1, 32'h90, 5'd2, 32'h0);
        step();
        drive_rr(5'd1, 32'h91, 5'd2, 32'h0);
        step();
        idle_inputs();
        check("arst_pre_rdy", 32'(in_ready), 32'd0);
        check("arst_pre_v", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("arst_after", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
